mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_BLOCK, default 8, words per cache-block fill.
REQ-002 SHALL have parameter MEM_LAT, default 4, memory read latency in cycles from enable to data_valid.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port i_req, input, 1, I-cache fill request, held until i_done.
REQ-006 SHALL have port i_addr, input, 16, I-cache miss address.
REQ-007 SHALL have port d_req, input, 1, D-cache request, held until d_done.
REQ-008 SHALL have port d_wr, input, 1, D-cache request type: 1 = word write, 0 = block fill.
REQ-009 SHALL have ports d_addr, input, 16 (D-cache address) and d_wdata, input, 16 (write data).
REQ-010 SHALL have ports i_done and d_done, output, 1 each, one-cycle completion pulses.
REQ-011 SHALL have ports i_fill_valid and d_fill_valid, output, 1 each, fill word strobes.
REQ-012 SHALL have ports fill_data, output, 16 (returned word) and fill_word, output, 3 (word index within block).
REQ-013 SHALL have ports mem_en, output, 1; mem_wr, output, 1; mem_addr, output, 16; mem_wdata, output, 16.
REQ-014 SHALL have ports mem_rdata, input, 16 and mem_rvalid, input, 1, from the memory.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, ISSUE and DRAIN.
REQ-016 In IDLE with exactly one requester active, SHALL grant it; with both active, SHALL grant the requester not served last; last-served flag resets to I, so D wins the first tie.
REQ-017 On grant, SHALL latch the owner, the address (fills: low 4 bits forced to 0), and for writes d_wdata.
REQ-018 On a D grant with d_wr=1, SHALL go IDLE->WRITE: one cycle with mem_en=1, mem_wr=1, latched address and data, and d_done=1; then return to IDLE.
REQ-019 On a fill grant, SHALL go IDLE->ISSUE: WORDS_PER_BLOCK consecutive cycles with mem_en=1, mem_wr=0, and mem_addr = base + 2*issue_cnt; then go to DRAIN.
REQ-020 Issue addresses SHALL stay inside the aligned block; there is no 16-bit wrap.
REQ-021 In ISSUE or DRAIN, each mem_rvalid SHALL drive fill_data=mem_rdata, fill_word=rx_cnt and the owner's fill_valid that same cycle, then increment rx_cnt.
REQ-022 On the WORDS_PER_BLOCK-th return, SHALL pulse the owner's done that cycle and enter IDLE next cycle.
REQ-023 Fill timing with defaults: issue at t0..t7, returns at t4..t11, done at t11, next grant evaluated at t12.
REQ-024 mem_rvalid in IDLE or WRITE SHALL be ignored; no strobe or counter change.
REQ-025 Request deassertion mid-operation SHALL be ignored; the operation completes.
REQ-026 Outside WRITE/ISSUE, mem_en and mem_wr SHALL be 0; outside return cycles, both fill_valid SHALL be 0.
REQ-027 i_req SHALL never cause a write; I-cache requests are fills only.
REQ-028 The non-owner's done and fill_valid SHALL remain 0 throughout an operation.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, clear issue_cnt, rx_cnt and latches, and set last-served to I.
REQ-030 During reset, all outputs SHALL be 0.
REQ-031 Reset mid-fill SHALL abort the fill with no done pulse; memory returns still in flight after release SHALL be ignored per REQ-024.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum, WORDS_PER_BLOCK, MEM_LAT and the owner encoding (OWN_I, OWN_D).
REQ-033 A sub-module mem_arb_rr (2-way round-robin picker with last-served flag) SHALL be used; counters and FSM stay in mem_arbiter.
REQ-034 Total RTL SHALL be about 150-300 lines.

Verification
REQ-035 i_req=1, i_addr=0x1236, memory pre-loaded -> mem_addr 0x1230..0x123E at t0..t7; i_fill_valid at t4..t11 with fill_word 0..7; i_done at t11 only.
REQ-036 d_req=1, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> one WRITE cycle with mem_en=mem_wr=1 and d_done=1; a later fill of 0x0040 returns 0xBEEF as word 0.
REQ-037 i_req and d_req (fill) asserted together from reset -> D served first; I granted at the cycle after d_done; a repeat tie then grants I.
REQ-038 rst_n pulsed low at t5 of a fill -> outputs 0 immediately; late mem_rvalid after release produces no fill_valid; next request behaves per REQ-035.
REQ-039 i_req dropped at t2 of a fill -> all 8 words and i_done still delivered.
REQ-040 Stray mem_rvalid=1 in IDLE -> no fill_valid and rx_cnt unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the I/D memory arbiter
package mem_arb_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LAT         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Byte address of the first word of the block holding addr (16-bit words).
  function automatic logic [15:0] block_base(input logic [15:0] addr, input int words);
    return addr & ~16'(2 * words - 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker between I-cache and D-cache
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   take,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  owner_e last_q;

  assign gnt_valid = i_req | d_req;

  // On a tie the side that was not served last wins.
  always_comb begin
    gnt_owner = OWN_I;
    if (i_req && d_req) begin
      gnt_owner = (last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      gnt_owner = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else if (take) begin
      last_q <= gnt_owner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates I-cache fills and D-cache fills/writes onto one memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = mem_arb_pkg::WORDS_PER_BLOCK,
  parameter int MEM_LAT         = mem_arb_pkg::MEM_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_done,
  output logic        d_done,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int              CNT_W    = $clog2(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  state_e           state_q, state_d;
  owner_e           owner_q;
  logic [15:0]      addr_q, wdata_q;
  logic [CNT_W-1:0] issue_cnt, rx_cnt;

  logic   gnt_valid, take, in_fill, ret, last_ret, done;
  owner_e gnt_owner;

  mem_arb_rr u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .d_req     (d_req),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  // Returns only count while a fill is in progress; stale ones in IDLE/WRITE are dropped.
  assign in_fill  = (state_q == ISSUE) || (state_q == DRAIN);
  assign ret      = in_fill && mem_rvalid;
  assign last_ret = ret && (rx_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    done      = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          take    = 1'b1;
          state_d = (gnt_owner == OWN_D && d_wr) ? WRITE : ISSUE;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        done      = 1'b1;
        state_d   = IDLE;
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = addr_q + 16'({issue_cnt, 1'b0});
        if (last_ret) begin
          state_d = IDLE;
        end else if (issue_cnt == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_ret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (last_ret) begin
      done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else if (take) begin
      owner_q   <= gnt_owner;
      issue_cnt <= '0;
      rx_cnt    <= '0;
      if (gnt_owner == OWN_D) begin
        addr_q  <= d_wr ? d_addr : block_base(d_addr, WORDS_PER_BLOCK);
        wdata_q <= d_wr ? d_wdata : 16'h0000;
      end else begin
        addr_q  <= block_base(i_addr, WORDS_PER_BLOCK);
        wdata_q <= 16'h0000;
      end
    end else begin
      if (state_q == ISSUE) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (ret) begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  assign i_done       = done && (owner_q == OWN_I);
  assign d_done       = done && (owner_q == OWN_D);
  assign i_fill_valid = ret && (owner_q == OWN_I);
  assign d_fill_valid = ret && (owner_q == OWN_D);
  assign fill_data    = ret ? mem_rdata : 16'h0000;
  assign fill_word    = ret ? 3'(rx_cnt) : 3'd0;

endmodule
